mem_cmd_sequencer: RTL

MEM_CMD_SEQUENCER -- requirements
Module: mem_cmd_sequencer

---
 rtl/mem_seq_pkg.sv | 52 +++++
 rtl/mem_trig_hs.sv | 32 +++
 rtl/mem_cmd_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - flash opcodes, request op codes and sequencer state encoding
package mem_seq_pkg;

   localparam logic [7:0] OPC_READ = 8'h03;
   localparam logic [7:0] OPC_WREN = 8'h06;
   localparam logic [7:0] OPC_PP   = 8'h02;
   localparam logic [7:0] OPC_SE   = 8'hD8;
   localparam logic [7:0] OPC_BE   = 8'hC7;
   localparam logic [7:0] OPC_RDSR = 8'h05;

   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_PROG   = 2'd1,
      OP_SERASE = 2'd2,
      OP_BERASE = 2'd3
   } req_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_TRIG = 3'd2,
      ST_BUSY = 3'd3,
      ST_EVAL = 3'd4,
      ST_RESP = 3'd5
   } seq_state_e;

   // Status polls repeat on this step until WIP clears.
   localparam logic [1:0] STEP_LAST = 2'd2;

   function automatic logic [7:0] step_cmd(input req_op_e op, input logic [1:0] step);
      logic [7:0] cmd;
      if (op == OP_READ) begin
         cmd = OPC_READ;
      end else if (step == 2'd0) begin
         cmd = OPC_WREN;
      end else if (step == 2'd1) begin
         case (op)
            OP_PROG:   cmd = OPC_PP;
            OP_SERASE: cmd = OPC_SE;
            default:   cmd = OPC_BE;
         endcase
      end else begin
         cmd = OPC_RDSR;
      end
      return cmd;
   endfunction

   function automatic logic cmd_has_addr(input logic [7:0] cmd);
      return (cmd == OPC_READ) || (cmd == OPC_PP) || (cmd == OPC_SE);
   endfunction

endpackage

// File: rtl/mem_trig_hs.sv
// rtl/mem_trig_hs.sv - trigger/busy handshake toward the memory controller
module mem_trig_hs (
   input  logic CLK,
   input  logic RST_N,
   input  logic start,
   input  logic MEM_busy,
   output logic MEMTRIG,
   output logic step_done
);

   logic trig_q;
   logic wait_idle_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         trig_q      <= 1'b0;
         wait_idle_q <= 1'b0;
      end else if (start) begin
         trig_q      <= 1'b1;
         wait_idle_q <= 1'b0;
      end else if (trig_q && MEM_busy) begin
         trig_q      <= 1'b0;
         wait_idle_q <= 1'b1;
      end else if (wait_idle_q && !MEM_busy) begin
         wait_idle_q <= 1'b0;
      end
   end

   assign MEMTRIG   = trig_q;
   assign step_done = wait_idle_q && !MEM_busy;

endmodule

// File: rtl/mem_cmd_sequencer.sv
// rtl/mem_cmd_sequencer.sv - flash command sequencer; MEMSEQ_TIMEOUT_EN adds a status-poll timeout
module mem_cmd_sequencer
   import mem_seq_pkg::*;
#(
   parameter logic [15:0] POLL_MAX = 16'd50000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [1:0]  REQ_OP,
   input  logic [23:0] REQ_ADDR,
   input  logic [23:0] REQ_DATA,
   output logic        RSP_VALID,
   output logic [47:0] RSP_DATA,
   output logic        RSP_ERR,
   output logic [7:0]  MEMCMD,
   output logic [23:0] MEMADDR,
   output logic [23:0] MEMVAL,
   output logic        MEMTRIG,
   output logic        MEMQUAD,
   input  logic        MEM_busy,
   input  logic [47:0] MEMDATA
);

   seq_state_e  state_q, state_d;
   req_op_e     op_q;
   logic [23:0] addr_q, data_q;
   logic [1:0]  step_q, step_next;
   logic        ready_q;
   logic [47:0] rsp_data_q;
   logic [7:0]  cmd_q;
   logic [23:0] mem_addr_q, mem_val_q;

   logic        accept, hs_start, eval_reload, rsp_valid, cmd_load, step_done;
   logic        is_poll, poll_timeout, eval_done;
   req_op_e     cmd_op;
   logic [1:0]  cmd_step;
   logic [23:0] cmd_addr, cmd_data;
   logic [7:0]  cmd_d;

   assign is_poll   = (cmd_q == OPC_RDSR);
   assign eval_done = (op_q == OP_READ) || (is_poll && (!MEMDATA[0] || poll_timeout));
   assign step_next = (step_q == STEP_LAST) ? STEP_LAST : step_q + 2'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_TRIG;
         ST_TRIG: if (MEM_busy) state_d = ST_BUSY;
         ST_BUSY: if (step_done) state_d = ST_EVAL;
         ST_EVAL: state_d = eval_done ? ST_RESP : ST_LOAD;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      accept      = 1'b0;
      hs_start    = 1'b0;
      eval_reload = 1'b0;
      rsp_valid   = 1'b0;
      case (state_q)
         ST_IDLE: accept      = REQ_VALID && ready_q;
         ST_LOAD: hs_start    = 1'b1;
         ST_EVAL: eval_reload = !eval_done;
         ST_RESP: rsp_valid   = 1'b1;
         default: ;
      endcase
   end

   // On acceptance the first command is built straight from the request inputs.
   assign cmd_load = accept || eval_reload;
   assign cmd_op   = accept ? req_op_e'(REQ_OP) : op_q;
   assign cmd_step = accept ? 2'd0 : step_next;
   assign cmd_addr = accept ? REQ_ADDR : addr_q;
   assign cmd_data = accept ? REQ_DATA : data_q;
   assign cmd_d    = step_cmd(cmd_op, cmd_step);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q       <= OP_READ;
         addr_q     <= '0;
         data_q     <= '0;
         step_q     <= '0;
         ready_q    <= 1'b0;
         rsp_data_q <= '0;
         cmd_q      <= '0;
         mem_addr_q <= '0;
         mem_val_q  <= '0;
      end else begin
         ready_q <= (state_d == ST_IDLE);
         if (accept) begin
            op_q   <= req_op_e'(REQ_OP);
            addr_q <= REQ_ADDR;
            data_q <= REQ_DATA;
            step_q <= 2'd0;
         end else if (eval_reload) begin
            step_q <= step_next;
         end
         if (cmd_load) begin
            cmd_q      <= cmd_d;
            mem_addr_q <= cmd_has_addr(cmd_d) ? cmd_addr : 24'h0;
            mem_val_q  <= (cmd_d == OPC_PP) ? cmd_data : 24'h0;
         end
         if ((state_q == ST_EVAL) && eval_done) begin
            rsp_data_q <= (op_q == OP_READ) ? MEMDATA : {40'h0, MEMDATA[7:0]};
         end
      end
   end

`ifdef MEMSEQ_TIMEOUT_EN
   logic [15:0] poll_cnt_q;
   logic        rsp_err_q;

   assign poll_timeout = (poll_cnt_q >= POLL_MAX);

   // Counts issued status polls; saturates instead of wrapping.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         poll_cnt_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            poll_cnt_q <= '0;
         end else if (cmd_load && (cmd_d == OPC_RDSR) && (poll_cnt_q != 16'hFFFF)) begin
            poll_cnt_q <= poll_cnt_q + 16'd1;
         end
         if ((state_q == ST_EVAL) && eval_done) begin
            rsp_err_q <= is_poll && MEMDATA[0] && poll_timeout;
         end
      end
   end

   assign RSP_ERR = rsp_err_q && rsp_valid;
`else
   logic unused_poll_max;
   assign unused_poll_max = ^POLL_MAX;
   assign poll_timeout    = 1'b0;
   assign RSP_ERR         = 1'b0;
`endif

   mem_trig_hs u_trig_hs (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (hs_start),
      .MEM_busy  (MEM_busy),
      .MEMTRIG   (MEMTRIG),
      .step_done (step_done)
   );

   assign REQ_READY = ready_q;
   assign RSP_VALID = rsp_valid;
   assign RSP_DATA  = rsp_data_q;
   assign MEMCMD    = cmd_q;
   assign MEMADDR   = mem_addr_q;
   assign MEMVAL    = mem_val_q;
   assign MEMQUAD   = 1'b0;

endmodule
